// File: rtl/otp_seg_scan.sv
// otp_seg_scan: two-digit multiplexed seven-segment driver, outputs registered (one-cycle latency), no backpressure.
// Optional user-display blink on mismatch is generated only when OTP_DISP_BLINK_EN is defined.
module otp_seg_scan #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] otp_value,
    input  logic       otp_valid,
    input  logic [7:0] user_value,
    input  logic [1:0] user_digits,
    input  logic       mismatch,
    output logic [6:0] lfsr_out,
    output logic [6:0] user_out,
    output logic [1:0] an,
    output logic       scan_tick
);
    localparam int             PCW     = $clog2(SCAN_DIV);
    localparam logic [PCW-1:0] PC_MAX  = PCW'(SCAN_DIV - 1);
    localparam logic [6:0]     SEG_OFF = 7'h7F;

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic [PCW-1:0] pc_q, pc_d;
    logic           dsel_q, dsel_d;
    logic           blank_d;
    logic [1:0]     an_q, an_d;
    logic [6:0]     lfsr_q, lfsr_d;
    logic [6:0]     user_q, user_d;
    logic           tick_q;
    logic [3:0]     otp_nib, user_nib;
    logic           user_on;
    logic           blink_hide;

`ifdef OTP_DISP_BLINK_EN
    localparam int             BCW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BCW-1:0] BC_MAX = BCW'(BLINK_DIV - 1);

    logic [BCW-1:0] bcnt_q, bcnt_d;
    logic           bphase_q, bphase_d;

    // Counts slot boundaries while mismatch holds; dropping mismatch restarts visible.
    always_comb begin
        bcnt_d   = bcnt_q;
        bphase_d = bphase_q;
        if (!mismatch) begin
            bcnt_d   = '0;
            bphase_d = 1'b0;
        end else if (blank_d) begin
            if (bcnt_q == BC_MAX) begin
                bcnt_d   = '0;
                bphase_d = ~bphase_q;
            end else begin
                bcnt_d = bcnt_q + BCW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcnt_q   <= '0;
            bphase_q <= 1'b0;
        end else begin
            bcnt_q   <= bcnt_d;
            bphase_q <= bphase_d;
        end
    end

    assign blink_hide = mismatch & bphase_d;
`else
    logic unused_blink;
    assign unused_blink = mismatch & (BLINK_DIV > 0);
    assign blink_hide   = 1'b0;
`endif

    // Outputs are built from next-state scan position so they line up with pc after the edge.
    always_comb begin
        pc_d = pc_q + PCW'(1);
        if (pc_q == PC_MAX) begin
            pc_d = '0;
        end
        blank_d  = (pc_d == '0);
        dsel_d   = blank_d ? ~dsel_q : dsel_q;
        otp_nib  = dsel_d ? otp_value[7:4]  : otp_value[3:0];
        user_nib = dsel_d ? user_value[7:4] : user_value[3:0];
        user_on  = dsel_d ? user_digits[1]  : (user_digits != 2'b00);

        an_d = 2'b11;
        if (!blank_d) begin
            an_d = dsel_d ? 2'b01 : 2'b10;
        end
        lfsr_d = (blank_d || !otp_valid) ? SEG_OFF : hex_seg(otp_nib);
        user_d = (blank_d || !user_on || blink_hide) ? SEG_OFF : hex_seg(user_nib);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q   <= '0;
            dsel_q <= 1'b0;
            an_q   <= 2'b11;
            lfsr_q <= SEG_OFF;
            user_q <= SEG_OFF;
            tick_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            dsel_q <= dsel_d;
            an_q   <= an_d;
            lfsr_q <= lfsr_d;
            user_q <= user_d;
            tick_q <= blank_d;
        end
    end

    assign an        = an_q;
    assign lfsr_out  = lfsr_q;
    assign user_out  = user_q;
    assign scan_tick = tick_q;
endmodule
